// File: rtl/euclid_pkg.sv
// rtl/euclid_pkg.sv - shared register map, state encoding and job record for euclid_sched
package euclid_pkg;

    localparam logic [31:0] ADDR_CTRL   = 32'd0;
    localparam logic [31:0] ADDR_STATUS = 32'd1;
    localparam logic [31:0] ADDR_X1     = 32'd2;
    localparam logic [31:0] ADDR_X2     = 32'd3;
    localparam logic [31:0] ADDR_Y1     = 32'd4;
    localparam logic [31:0] ADDR_Y2     = 32'd5;
    localparam logic [31:0] ADDR_RESULT = 32'd6;
    localparam logic [31:0] ADDR_COUNT  = 32'd7;
    localparam logic [31:0] ADDR_CYCLES = 32'd8;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_JOBS_LSB = 4;
    localparam int STAT_RES_LSB  = 12;
    localparam int STAT_OVERFLOW = 20;

    localparam logic [31:0] READ_IDLE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y1;
        logic [31:0] y2;
    } job_t;

    function automatic logic [31:0] status_word(
        input logic       busy,
        input logic       done,
        input logic [7:0] jobs,
        input logic [7:0] results,
        input logic       overflow
    );
        logic [31:0] w;
        w                       = '0;
        w[STAT_BUSY]            = busy;
        w[STAT_DONE]            = done;
        w[STAT_JOBS_LSB +: 8]   = jobs;
        w[STAT_RES_LSB +: 8]    = results;
        w[STAT_OVERFLOW]        = overflow;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and synchronous flush
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/euclid_sched.sv
// rtl/euclid_sched.sv - job/result queueing scheduler for one euclid_dist pipeline; EUCLID_SCHED_TIMESTAMP_EN adds CYCLES
module euclid_sched
    import euclid_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DEPTH         = 8,
    parameter int DIST_LATENCY  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] slave_address,
    input  logic                     slave_read,
    output logic [31:0]              slave_readdata,
    input  logic                     slave_write,
    input  logic [31:0]              slave_writedata,
    output logic                     slave_waitrequest,
    output logic                     done_irq,
    output logic [31:0]              dist_x1,
    output logic [31:0]              dist_x2,
    output logic [31:0]              dist_y1,
    output logic [31:0]              dist_y2,
    output logic                     dist_in_valid,
    input  logic [31:0]              dist_result
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                  state;
    logic [2:0]              ctrl_q;
    logic [31:0]             x1_q;
    logic [31:0]             x2_q;
    logic [31:0]             y1_q;
    logic                    overflow_q;
    logic [31:0]             result_count;
    logic [CW-1:0]           inflight;
    logic [DIST_LATENCY-1:0] sr;

    logic [31:0] addr_w;
    logic        wr_ctrl;
    logic        clear_req;
    logic        start_req;
    logic        push_req;
    logic        pop_req;
    logic        issue;
    logic        tail;
    logic        credit;
    logic        drain_done;

    job_t          job_in;
    job_t          job_head;
    logic          job_full;
    logic          job_empty;
    logic [CW-1:0] job_count;
    logic [31:0]   res_head;
    logic          res_full;
    logic          res_empty;
    logic [CW-1:0] res_count;

    assign slave_waitrequest = 1'b0;

    assign addr_w    = 32'(slave_address);
    assign wr_ctrl   = slave_write && (addr_w == ADDR_CTRL);
    assign clear_req = wr_ctrl && slave_writedata[CTRL_CLEAR];
    assign start_req = wr_ctrl && slave_writedata[CTRL_START] && !clear_req;
    assign push_req  = slave_write && (addr_w == ADDR_Y2);
    assign pop_req   = slave_read && (addr_w == ADDR_RESULT);

    // Credit reserves a result slot for every job already in the pipeline.
    assign credit     = ((32'(inflight) + 32'(res_count)) < DEPTH) && !res_full;
    assign issue      = (state == ISSUE) && !job_empty && credit;
    assign tail       = sr[DIST_LATENCY-1];
    assign drain_done = (inflight == '0) || ((inflight == CW'(1)) && tail);

    assign job_in = '{x1: x1_q, x2: x2_q, y1: y1_q, y2: slave_writedata};

    sync_fifo #(
        .WIDTH ($bits(job_t)),
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_req),
        .push      (push_req),
        .push_data (job_in),
        .pop       (issue),
        .head      (job_head),
        .full      (job_full),
        .empty     (job_empty),
        .count     (job_count)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_req),
        .push      (tail),
        .push_data (dist_result),
        .pop       (pop_req),
        .head      (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            dist_in_valid <= 1'b0;
            dist_x1       <= '0;
            dist_x2       <= '0;
            dist_y1       <= '0;
            dist_y2       <= '0;
            done_irq      <= 1'b0;
        end else begin
            dist_in_valid <= 1'b0;
            done_irq      <= (state == DONE) && ctrl_q[CTRL_IRQ_EN];
            if (clear_req) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_req) begin
                            state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (issue) begin
                            dist_in_valid <= 1'b1;
                            dist_x1       <= job_head.x1;
                            dist_x2       <= job_head.x2;
                            dist_y1       <= job_head.y1;
                            dist_y2       <= job_head.y2;
                        end else if (job_empty) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!job_empty) begin
                            state <= ISSUE;
                        end else if (drain_done) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        if (start_req) begin
                            state <= ISSUE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q       <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            overflow_q   <= 1'b0;
            result_count <= '0;
            inflight     <= '0;
            sr           <= '0;
        end else begin
            ctrl_q[CTRL_START] <= 1'b0;
            ctrl_q[CTRL_CLEAR] <= 1'b0;
            if (wr_ctrl) begin
                ctrl_q <= slave_writedata[2:0];
            end
            if (slave_write && (addr_w == ADDR_X1)) begin
                x1_q <= slave_writedata;
            end
            if (slave_write && (addr_w == ADDR_X2)) begin
                x2_q <= slave_writedata;
            end
            if (slave_write && (addr_w == ADDR_Y1)) begin
                y1_q <= slave_writedata;
            end
            if (clear_req) begin
                overflow_q   <= 1'b0;
                result_count <= '0;
                inflight     <= '0;
                sr           <= '0;
            end else begin
                if (push_req && job_full) begin
                    overflow_q <= 1'b1;
                end
                sr <= (sr << 1) | DIST_LATENCY'(dist_in_valid);
                if (tail) begin
                    result_count <= result_count + 32'd1;
                end
                case ({issue, tail})
                    2'b10:   inflight <= inflight + CW'(1);
                    2'b01:   inflight <= inflight - CW'(1);
                    default: inflight <= inflight;
                endcase
            end
        end
    end

`ifdef EUCLID_SCHED_TIMESTAMP_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else if (clear_req) begin
            cycles_q <= '0;
        end else if (start_req && ((state == IDLE) || (state == DONE))) begin
            cycles_q <= '0;
        end else if (((state == ISSUE) || (state == DRAIN)) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
`endif

    always_comb begin
        slave_readdata = READ_IDLE;
        if (slave_read) begin
            case (addr_w)
                ADDR_CTRL:   slave_readdata = {29'b0, ctrl_q};
                ADDR_STATUS: slave_readdata = status_word((state == ISSUE) || (state == DRAIN),
                                                          state == DONE, 8'(job_count),
                                                          8'(res_count), overflow_q);
                ADDR_X1:     slave_readdata = x1_q;
                ADDR_X2:     slave_readdata = x2_q;
                ADDR_Y1:     slave_readdata = y1_q;
                ADDR_RESULT: slave_readdata = res_empty ? READ_IDLE : res_head;
                ADDR_COUNT:  slave_readdata = result_count;
`ifdef EUCLID_SCHED_TIMESTAMP_EN
                ADDR_CYCLES: slave_readdata = cycles_q;
`endif
                default:     slave_readdata = READ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_euclid_sched.sv
// tb/tb_euclid_sched.sv - directed vector bench for euclid_sched with a behavioural euclid_dist stand-in
module tb_euclid_sched;

    localparam int AW = 4;
    localparam int D  = 8;
    localparam int L  = 4;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_X1     = 4'd2;
    localparam logic [3:0] A_X2     = 4'd3;
    localparam logic [3:0] A_Y1     = 4'd4;
    localparam logic [3:0] A_Y2     = 4'd5;
    localparam logic [3:0] A_RESULT = 4'd6;
    localparam logic [3:0] A_COUNT  = 4'd7;
    localparam logic [3:0] A_CYCLES = 4'd8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] slave_address = '0;
    logic          slave_read = 1'b0;
    logic [31:0]   slave_readdata;
    logic          slave_write = 1'b0;
    logic [31:0]   slave_writedata = '0;
    logic          slave_waitrequest;
    logic          done_irq;
    logic [31:0]   dist_x1, dist_x2, dist_y1, dist_y2;
    logic          dist_in_valid;
    logic [31:0]   dist_result;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int issue_log[$];

    logic [31:0] pipe [L];

    euclid_sched #(
        .ADDRESS_WIDTH (AW),
        .DEPTH         (D),
        .DIST_LATENCY  (L)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .slave_waitrequest (slave_waitrequest),
        .done_irq          (done_irq),
        .dist_x1           (dist_x1),
        .dist_x2           (dist_x2),
        .dist_y1           (dist_y1),
        .dist_y2           (dist_y2),
        .dist_in_valid     (dist_in_valid),
        .dist_result       (dist_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt_dist(input logic [31:0] x1, input logic [31:0] x2,
                                               input logic [31:0] y1, input logic [31:0] y2);
        int dx, dy, d2, r;
        dx = int'(x2) - int'(x1);
        dy = int'(y2) - int'(y1);
        d2 = dx * dx + dy * dy;
        r  = 0;
        while ((r + 1) * (r + 1) <= d2) r++;
        return 32'(r);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= dist_in_valid ? isqrt_dist(dist_x1, dist_x2, dist_y1, dist_y2) : 32'hBAD0_0000;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign dist_result = pipe[L-1];

    always @(negedge clk) begin
        if (rst && dist_in_valid) issue_log.push_back(cyc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read    = 1'b1;
        #1 d = slave_readdata;
        @(negedge clk);
        slave_read    = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic push_job(input int x1, input int x2, input int y1, input int y2);
        bus_write(A_X1, 32'(x1));
        bus_write(A_X2, 32'(x2));
        bus_write(A_Y1, 32'(y1));
        bus_write(A_Y2, 32'(y2));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output int dcyc, output logic irq_at_done);
        logic [31:0] d;
        int          c;
        logic        irq;
        bit          found;
        found       = 1'b0;
        dcyc        = 0;
        irq_at_done = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            c   = cyc;
            irq = done_irq;
            bus_read(A_STATUS, d);
            if (d[1]) begin
                found       = 1'b1;
                dcyc        = c;
                irq_at_done = irq;
            end
        end
        check("done_reached", {31'b0, found}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int          b;
        int          dcyc;
        logic        irq0;
        logic [31:0] d;

        tbl[0]  = '{A_STATUS, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{A_COUNT,  1'b0, 32'h0, 32'h0};
        tbl[2]  = '{A_RESULT, 1'b0, 32'h0, 32'hFFFF_FFFF};
        tbl[3]  = '{A_CTRL,   1'b0, 32'h0, 32'h0};
        tbl[4]  = '{A_X1,     1'b1, 32'h1234_5678, 32'h0};
        tbl[5]  = '{A_X2,     1'b1, 32'hDEAD_BEEF, 32'h0};
        tbl[6]  = '{A_Y1,     1'b1, 32'h0000_CAFE, 32'h0};
        tbl[7]  = '{A_X1,     1'b0, 32'h0, 32'h1234_5678};
        tbl[8]  = '{A_X2,     1'b0, 32'h0, 32'hDEAD_BEEF};
        tbl[9]  = '{A_Y1,     1'b0, 32'h0, 32'h0000_CAFE};
        tbl[10] = '{A_CTRL,   1'b1, 32'h2, 32'h0};
        tbl[11] = '{A_CTRL,   1'b0, 32'h0, 32'h2};
        tbl[12] = '{A_CTRL,   1'b1, 32'h0, 32'h0};
        tbl[13] = '{4'd9,     1'b0, 32'h0, 32'hFFFF_FFFF};
        tbl[14] = '{4'd15,    1'b0, 32'h0, 32'hFFFF_FFFF};
`ifdef EUCLID_SCHED_TIMESTAMP_EN
        tbl[15] = '{A_CYCLES, 1'b0, 32'h0, 32'h0};
`else
        tbl[15] = '{A_CYCLES, 1'b0, 32'h0, 32'hFFFF_FFFF};
`endif
        tbl[16] = '{4'd12,    1'b1, 32'h1, 32'h0};

        // Reset state
        idle(3);
        #1;
        check("rst_readdata", slave_readdata, 32'hFFFF_FFFF);
        check("rst_irq", {31'b0, done_irq}, 32'h0);
        check("rst_valid", {31'b0, dist_in_valid}, 32'h0);
        check("rst_x1", dist_x1, 32'h0);
        check("rst_waitreq", {31'b0, slave_waitrequest}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
            else read_check($sformatf("table%0d", i), tbl[i].addr, tbl[i].exp);
        end
        read_check("ignored_write_status", A_STATUS, 32'h0);

        // Three-job batch
        push_job(0, 3, 0, 4);
        push_job(1, 4, 1, 5);
        push_job(2, 5, 2, 6);
        read_check("t1_pending", A_STATUS, 32'h0000_0030);
        b = issue_log.size();
        bus_write(A_CTRL, 32'h1);
        wait_done(dcyc, irq0);
        check("t1_issue_cnt", 32'(issue_log.size() - b), 32'd3);
        if (issue_log.size() >= b + 3) begin
            check("t1_consecutive", 32'(issue_log[b+2] - issue_log[b]), 32'd2);
            check("t1_done_latency", 32'(dcyc - issue_log[b]), 32'(3 + L));
        end
        read_check("t1_status", A_STATUS, 32'h0000_3002);
        read_check("t1_count", A_COUNT, 32'd3);
        read_check("t1_res0", A_RESULT, 32'd5);
        read_check("t1_res1", A_RESULT, 32'd5);
        read_check("t1_res2", A_RESULT, 32'd5);
        read_check("t1_res_empty", A_RESULT, 32'hFFFF_FFFF);
        read_check("t1_status_after", A_STATUS, 32'h0000_0002);

        // Job FIFO overflow
        bus_write(A_CTRL, 32'h4);
        for (int k = 0; k < D + 1; k++) push_job(1, 1, 1, 1);
        read_check("t2_overflow", A_STATUS, 32'h0010_0080);
        bus_write(A_CTRL, 32'h4);
        read_check("t2_cleared", A_STATUS, 32'h0);

        // Credit stall with results left unread
        for (int k = 1; k <= D; k++) push_job(0, 3 * k, 0, 4 * k);
        b = issue_log.size();
        bus_write(A_CTRL, 32'h1);
        idle(3);
        push_job(0, 27, 0, 36);
        push_job(0, 30, 0, 40);
        idle(30);
        check("t3_stall_issues", 32'(issue_log.size() - b), 32'(D));
        read_check("t3_stall_status", A_STATUS, 32'h0000_8021);
        read_check("t3_pop_first", A_RESULT, 32'd5);
        idle(20);
        check("t3_one_more_issue", 32'(issue_log.size() - b), 32'(D + 1));
        read_check("t3_status_one", A_STATUS, 32'h0000_8011);
        for (int k = 2; k <= D; k++) read_check($sformatf("t3_res%0d", k), A_RESULT, 32'(5 * k));
        idle(20);
        read_check("t3_res9", A_RESULT, 32'd45);
        read_check("t3_res10", A_RESULT, 32'd50);
        read_check("t3_done", A_STATUS, 32'h0000_0002);
        read_check("t3_count", A_COUNT, 32'd10);

        // Interrupt and CLEAR
        bus_write(A_CTRL, 32'h4);
        bus_write(A_CTRL, 32'h2);
        push_job(1, 4, 5, 9);
        bus_write(A_CTRL, 32'h3);
        wait_done(dcyc, irq0);
        check("t4_irq_lag", {31'b0, irq0}, 32'h0);
        check("t4_irq_high", {31'b0, done_irq}, 32'h1);
        bus_write(A_CTRL, 32'h4);
        @(negedge clk);
        check("t4_irq_cleared", {31'b0, done_irq}, 32'h0);
        read_check("t4_status", A_STATUS, 32'h0);
        read_check("t4_count", A_COUNT, 32'h0);

        // Reset mid-batch
        push_job(0, 6, 0, 8);
        push_job(0, 6, 0, 8);
        bus_write(A_CTRL, 32'h1);
        @(negedge clk);
        check("t5_inflight", {31'b0, dist_in_valid}, 32'h1);
        check("t5_x2_before", dist_x2, 32'd6);
        rst = 1'b0;
        #1;
        check("t5_valid_rst", {31'b0, dist_in_valid}, 32'h0);
        check("t5_x2_rst", dist_x2, 32'h0);
        check("t5_y2_rst", dist_y2, 32'h0);
        check("t5_irq_rst", {31'b0, done_irq}, 32'h0);
        check("t5_rdata_rst", slave_readdata, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        idle(10);
        read_check("t5_status", A_STATUS, 32'h0);
        read_check("t5_result", A_RESULT, 32'hFFFF_FFFF);
        read_check("t5_count", A_COUNT, 32'h0);

        // Optional cycle counter
`ifdef EUCLID_SCHED_TIMESTAMP_EN
        for (int k = 0; k < 4; k++) push_job(0, 3, 0, 4);
        bus_write(A_CTRL, 32'h1);
        wait_done(dcyc, irq0);
        read_check("t6_cycles", A_CYCLES, 32'(4 + L + 1));
        idle(5);
        read_check("t6_cycles_frozen", A_CYCLES, 32'(4 + L + 1));
        bus_write(A_CTRL, 32'h4);
        read_check("t6_cycles_clear", A_CYCLES, 32'h0);
`else
        read_check("t6_no_cycles", A_CYCLES, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
